// File: rtl/demux_pkg.sv
// demux_pkg: shared definitions for the four-way word distributor.
//   SEL_A..SEL_D : destination codes carried on IN_SEL
//   CNT_W        : width of the optional delivered-word counters
//   chan_state_e : per-channel holding-register state
package demux_pkg;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    localparam int CNT_W = 16;

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } chan_state_e;

endpackage

// File: rtl/demux_chan_reg.sv
// demux_chan_reg: one-entry holding register for a single output channel.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : write din into the register this edge (caller guarantees room)
//   din        : word to hold
//   valid      : register holds a word (registered, from FSM state)
//   ready      : downstream consumer ready; valid & ready drains the word
//   dout       : held word, stable while valid & ~ready
//   cnt        : delivered-word counter, present only with DEMUX_STATS_EN
module demux_chan_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] dout
`ifdef DEMUX_STATS_EN
   ,output logic [CNT_W-1:0] cnt
`endif
);

    chan_state_e      state_q;
    logic [WIDTH-1:0] dout_q;
    logic             drain;

    assign drain = (state_q == CH_FULL) & ready;
    assign valid = (state_q == CH_FULL);
    assign dout  = dout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CH_EMPTY;
            dout_q  <= '0;
        end else begin
            case (state_q)
                CH_EMPTY: begin
                    if (load) begin
                        state_q <= CH_FULL;
                        dout_q  <= din;
                    end
                end
                CH_FULL: begin
                    // A load while full only happens alongside a drain, so the
                    // new word replaces the departing one and the state stays FULL.
                    if (load) begin
                        dout_q <= din;
                    end else if (ready) begin
                        state_q <= CH_EMPTY;
                    end
                end
                default: state_q <= CH_EMPTY;
            endcase
        end
    end

`ifdef DEMUX_STATS_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Free-running wrap at all-ones is intentional.
    always_comb begin
        cnt_d = cnt_q;
        if (drain) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
`else
    logic unused_drain;
    assign unused_drain = drain;
`endif

endmodule

// File: rtl/four_way_demux.sv
// four_way_demux: 1-to-4 word distributor with one holding register per channel.
//   CLK, RST_N          : clock, asynchronous active-low reset
//   IN_DATA/IN_SEL      : word and destination (00=A 01=B 10=C 11=D)
//   IN_VALID/IN_READY   : input handshake; IN_READY depends only on IN_SEL and
//                         the selected channel's state/ready, never on IN_VALID
//   OUT_x/VALID_x/READY_x : per-channel output handshake, x in A..D
//   CNT_x               : per-channel delivered-word counters
// Optional feature macro: DEMUX_STATS_EN adds the CNT_A..CNT_D ports/counters.
module four_way_demux
    import demux_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic [1:0]       IN_SEL,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] OUT_A,
    output logic [WIDTH-1:0] OUT_B,
    output logic [WIDTH-1:0] OUT_C,
    output logic [WIDTH-1:0] OUT_D,
    output logic             VALID_A,
    output logic             VALID_B,
    output logic             VALID_C,
    output logic             VALID_D,
    input  logic             READY_A,
    input  logic             READY_B,
    input  logic             READY_C,
    input  logic             READY_D
`ifdef DEMUX_STATS_EN
   ,output logic [CNT_W-1:0] CNT_A,
    output logic [CNT_W-1:0] CNT_B,
    output logic [CNT_W-1:0] CNT_C,
    output logic [CNT_W-1:0] CNT_D
`endif
);

    logic ready_sel;
    logic accept;
    logic load_a, load_b, load_c, load_d;

    // The selected channel has room if it is empty or is draining this edge.
    always_comb begin
        ready_sel = 1'b0;
        case (IN_SEL)
            SEL_A:   ready_sel = ~VALID_A | READY_A;
            SEL_B:   ready_sel = ~VALID_B | READY_B;
            SEL_C:   ready_sel = ~VALID_C | READY_C;
            SEL_D:   ready_sel = ~VALID_D | READY_D;
            default: ready_sel = 1'b0;
        endcase
    end

    assign IN_READY = ready_sel;
    assign accept   = IN_VALID & ready_sel;

    assign load_a = accept & (IN_SEL == SEL_A);
    assign load_b = accept & (IN_SEL == SEL_B);
    assign load_c = accept & (IN_SEL == SEL_C);
    assign load_d = accept & (IN_SEL == SEL_D);

    demux_chan_reg #(.WIDTH(WIDTH)) u_chan_a (
        .clk(CLK), .rst_n(RST_N), .load(load_a), .din(IN_DATA),
        .valid(VALID_A), .ready(READY_A), .dout(OUT_A)
`ifdef DEMUX_STATS_EN
       ,.cnt(CNT_A)
`endif
    );

    demux_chan_reg #(.WIDTH(WIDTH)) u_chan_b (
        .clk(CLK), .rst_n(RST_N), .load(load_b), .din(IN_DATA),
        .valid(VALID_B), .ready(READY_B), .dout(OUT_B)
`ifdef DEMUX_STATS_EN
       ,.cnt(CNT_B)
`endif
    );

    demux_chan_reg #(.WIDTH(WIDTH)) u_chan_c (
        .clk(CLK), .rst_n(RST_N), .load(load_c), .din(IN_DATA),
        .valid(VALID_C), .ready(READY_C), .dout(OUT_C)
`ifdef DEMUX_STATS_EN
       ,.cnt(CNT_C)
`endif
    );

    demux_chan_reg #(.WIDTH(WIDTH)) u_chan_d (
        .clk(CLK), .rst_n(RST_N), .load(load_d), .din(IN_DATA),
        .valid(VALID_D), .ready(READY_D), .dout(OUT_D)
`ifdef DEMUX_STATS_EN
       ,.cnt(CNT_D)
`endif
    );

endmodule

// File: tb/tb_four_way_demux.sv
// tb_four_way_demux: directed stimulus with a per-channel scoreboard.
// Accepted words are queued per channel; a negedge monitor pops and compares
// whenever a channel drains (VALID_x & READY_x).
module tb_four_way_demux;

    logic        CLK;
    logic        RST_N;
    logic [15:0] IN_DATA;
    logic [1:0]  IN_SEL;
    logic        IN_VALID;
    logic        IN_READY;
    logic [15:0] OUT_A, OUT_B, OUT_C, OUT_D;
    logic        VALID_A, VALID_B, VALID_C, VALID_D;
    logic        READY_A, READY_B, READY_C, READY_D;
`ifdef DEMUX_STATS_EN
    logic [15:0] CNT_A, CNT_B, CNT_C, CNT_D;
`endif

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q [4][$];

    four_way_demux #(.WIDTH(16)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IN_DATA(IN_DATA), .IN_SEL(IN_SEL), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OUT_A(OUT_A), .OUT_B(OUT_B), .OUT_C(OUT_C), .OUT_D(OUT_D),
        .VALID_A(VALID_A), .VALID_B(VALID_B), .VALID_C(VALID_C), .VALID_D(VALID_D),
        .READY_A(READY_A), .READY_B(READY_B), .READY_C(READY_C), .READY_D(READY_D)
`ifdef DEMUX_STATS_EN
       ,.CNT_A(CNT_A), .CNT_B(CNT_B), .CNT_C(CNT_C), .CNT_D(CNT_D)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mon_chan(input int ch, input logic v, input logic r, input logic [15:0] d);
        logic [15:0] e;
        if (v && r) begin
            checks++;
            if (exp_q[ch].size() == 0) begin
                failures++;
                $display("FAIL drain_ch%0d: got unexpected word %h expected none", ch, d);
            end else begin
                e = exp_q[ch].pop_front();
                if (d !== e) begin
                    failures++;
                    $display("FAIL drain_ch%0d: got %h expected %h", ch, d, e);
                end
            end
        end
    endtask

    // Monitor: a drain is committed by the next rising edge, so sample mid-cycle.
    always @(negedge CLK) begin
        if (RST_N) begin
            mon_chan(0, VALID_A, READY_A, OUT_A);
            mon_chan(1, VALID_B, READY_B, OUT_B);
            mon_chan(2, VALID_C, READY_C, OUT_C);
            mon_chan(3, VALID_D, READY_D, OUT_D);
        end
    end

    // Present a word; returns the number of stalled cycles before acceptance.
    task automatic send(input logic [15:0] d, input logic [1:0] s, output int waits);
        waits    = 0;
        IN_DATA  = d;
        IN_SEL   = s;
        IN_VALID = 1'b1;
        @(negedge CLK);
        while (!IN_READY && waits < 200) begin
            @(negedge CLK);
            waits++;
        end
        if (!IN_READY) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got IN_READY=0 expected acceptance of %h", d);
        end else begin
            exp_q[s].push_back(d);
        end
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
    endtask

    task automatic clear_queues();
        for (int c = 0; c < 4; c++) exp_q[c].delete();
    endtask

    initial begin
        int w;
        int total;
        RST_N    = 1'b0;
        IN_DATA  = '0;
        IN_SEL   = '0;
        IN_VALID = 1'b0;
        {READY_A, READY_B, READY_C, READY_D} = 4'b0000;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_valid", 16'({VALID_A, VALID_B, VALID_C, VALID_D}), 16'h0);
        check("rst_in_ready", 16'(IN_READY), 16'h1);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // Fill all four channels with consumers stalled, then reset mid-cycle.
        send(16'hA0A0, 2'b00, w);
        send(16'hB0B0, 2'b01, w);
        send(16'hC0C0, 2'b10, w);
        send(16'hD0D0, 2'b11, w);
        check("fill_valid", 16'({VALID_A, VALID_B, VALID_C, VALID_D}), 16'hF);
        check("fill_out_c", OUT_C, 16'hC0C0);
        #2;
        RST_N = 1'b0;
        #1;
        clear_queues();
        check("amid_rst_valid", 16'({VALID_A, VALID_B, VALID_C, VALID_D}), 16'h0);
        check("amid_rst_out_a", OUT_A, 16'h0);
        check("amid_rst_out_d", OUT_D, 16'h0);
`ifdef DEMUX_STATS_EN
        check("amid_rst_cnt", CNT_A | CNT_B | CNT_C | CNT_D, 16'h0);
`endif
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // Routing with all consumers ready: one-cycle latency, one-cycle valid pulses.
        {READY_A, READY_B, READY_C, READY_D} = 4'b1111;
        send(16'h0001, 2'b00, w);
        check("route_wait_a", 16'(w), 16'h0);
        check("route_out_a", OUT_A, 16'h0001);
        check("route_vld_a", 16'(VALID_A), 16'h1);
        send(16'h0002, 2'b01, w);
        check("route_wait_b", 16'(w), 16'h0);
        check("route_vld_ab", 16'({VALID_A, VALID_B}), 16'h1);
        check("route_out_b", OUT_B, 16'h0002);
        send(16'h0003, 2'b10, w);
        check("route_wait_c", 16'(w), 16'h0);
        check("route_vld_bc", 16'({VALID_B, VALID_C}), 16'h1);
        send(16'h0004, 2'b11, w);
        check("route_wait_d", 16'(w), 16'h0);
        check("route_vld_cd", 16'({VALID_C, VALID_D}), 16'h1);
        check("route_out_d", OUT_D, 16'h0004);
        @(posedge CLK);
        #1;

        // Backpressure on B, with C traffic slipping past the stall.
        READY_B = 1'b0;
        send(16'hBEEF, 2'b01, w);
        check("bp_first_wait", 16'(w), 16'h0);
        IN_DATA  = 16'hCAFE;
        IN_SEL   = 2'b01;
        IN_VALID = 1'b1;
        repeat (2) begin
            @(negedge CLK);
            check("bp_in_ready", 16'(IN_READY), 16'h0);
            check("bp_hold_b", OUT_B, 16'hBEEF);
        end
        @(posedge CLK);
        #1;
        IN_DATA = 16'h1234;
        IN_SEL  = 2'b10;
        @(negedge CLK);
        check("iso_in_ready", 16'(IN_READY), 16'h1);
        exp_q[2].push_back(16'h1234);
        @(posedge CLK);
        #1;
        check("iso_out_c", OUT_C, 16'h1234);
        check("iso_vld_c", 16'(VALID_C), 16'h1);
        check("iso_hold_b", OUT_B, 16'hBEEF);
        IN_DATA = 16'hCAFE;
        IN_SEL  = 2'b01;
        READY_B = 1'b1;
        @(negedge CLK);
        check("bp_release_ready", 16'(IN_READY), 16'h1);
        exp_q[1].push_back(16'hCAFE);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        check("bp_out_cafe", OUT_B, 16'hCAFE);
        check("bp_vld_b", 16'(VALID_B), 16'h1);

        // Streaming 100 words to D.
        total = 0;
        for (int i = 0; i < 100; i++) begin
            send(16'h1000 + 16'(i), 2'b11, w);
            total += w;
        end
        check("stream_stalls", 16'(total), 16'h0);
        check("stream_last", OUT_D, 16'h1063);

`ifdef DEMUX_STATS_EN
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        clear_queues();
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        check("stats_rst_a", CNT_A, 16'h0);
        for (int i = 0; i < 65537; i++) send(16'(i), 2'b00, w);
        repeat (2) @(posedge CLK);
        #1;
        check("stats_wrap_a", CNT_A, 16'h0001);
        check("stats_b", CNT_B, 16'h0);
        check("stats_c", CNT_C, 16'h0);
        check("stats_d", CNT_D, 16'h0);
`endif

        // Drain everything and confirm nothing was lost.
        IN_VALID = 1'b0;
        {READY_A, READY_B, READY_C, READY_D} = 4'b1111;
        repeat (3) @(posedge CLK);
        #1;
        for (int c = 0; c < 4; c++) check($sformatf("queue_empty_ch%0d", c), 16'(exp_q[c].size()), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
